// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game-flow sequencer for the VGA display path.
// Steps TITLE -> LOAD1 -> PLAY1 -> WIN1 -> LOAD2 -> PLAY2 -> WIN2 -> TITLE,
// drives the mode flags and staggers per-object enables one reveal step at a time.
// Ports:
//   Clk, Reset      : clock, synchronous active-high reset
//   frame_clk       : VGA vsync, rising edge = one frame tick
//   start_key       : Enter key level (rising edge used)
//   level_done      : all blocks of the current level painted
//   ball_dead       : a ball was lost
//   title, pstart, level_one, level_two, level_active : registered mode flags
//   level_load      : one-cycle pulse on entry to a load state
//   block_ready     : per-block draw/collide enables
//   rect_ready      : per-rectangle draw/collide enables
module game_flow_ctrl #(
  parameter int unsigned BLINK_FRAMES    = 30,
  parameter int unsigned REVEAL_FRAMES   = 4,
  parameter int unsigned WIN_HOLD_FRAMES = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       level_done,
  input  logic       ball_dead,
  output logic       title,
  output logic       pstart,
  output logic       level_one,
  output logic       level_two,
  output logic       level_active,
  output logic       level_load,
  output logic [0:9] block_ready,
  output logic [0:2] rect_ready
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 4;

  localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] REVEAL_LAST = CNT_W'(REVEAL_FRAMES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_HOLD_FRAMES - 1);
  localparam logic [IDX_W-1:0] L1_BLOCKS   = IDX_W'(5);
  localparam logic [IDX_W-1:0] L2_BLOCKS   = IDX_W'(10);

  typedef enum logic [2:0] {
    S_TITLE, S_LOAD1, S_PLAY1, S_WIN1, S_LOAD2, S_PLAY2, S_WIN2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [0:9]         blk_q, blk_d;
  logic [0:2]         rect_q, rect_d;
  logic               title_q, title_d;
  logic               pstart_q, pstart_d;
  logic               level_one_q, level_one_d;
  logic               level_two_q, level_two_d;
  logic               level_active_q, level_active_d;
  logic               level_load_q, level_load_d;
  logic               fsync1_q, fsync2_q, fsync3_q;
  logic               tick_q, tick_d;
  logic               start_prev_q;
  logic               start_edge_c;
  logic               entering_c;
  logic               to_load_c;
  logic               load1_c;
  logic [IDX_W-1:0]   nblocks_c;

  // Next-state, reveal sequencing and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = tick_q ? cnt_q + CNT_W'(1) : cnt_q;
    idx_d        = idx_q;
    blk_d        = blk_q;
    rect_d       = rect_q;
    pstart_d     = pstart_q;
    tick_d       = fsync2_q & ~fsync3_q;
    start_edge_c = start_key & ~start_prev_q;
    load1_c      = (state_q == S_LOAD1);
    nblocks_c    = load1_c ? L1_BLOCKS : L2_BLOCKS;

    case (state_q)
      S_TITLE: begin
        if (start_edge_c) begin
          state_d = S_LOAD1;
        end else if (tick_q && cnt_q == BLINK_LAST) begin
          pstart_d = ~pstart_q;
          cnt_d    = '0;
        end
      end
      S_LOAD1, S_LOAD2: begin
        if (tick_q && cnt_q == REVEAL_LAST) begin
          cnt_d = '0;
          if (idx_q < nblocks_c) begin
            blk_d[idx_q] = 1'b1;
            idx_d        = idx_q + IDX_W'(1);
          end else begin
            // Step after the last block enables the rectangles and starts play.
            rect_d  = load1_c ? 3'b100 : 3'b111;
            state_d = load1_c ? S_PLAY1 : S_PLAY2;
          end
        end
      end
      S_PLAY1: begin
        if (level_done)     state_d = S_WIN1;
        else if (ball_dead) state_d = S_LOAD1;
      end
      S_PLAY2: begin
        if (level_done)     state_d = S_WIN2;
        else if (ball_dead) state_d = S_LOAD2;
      end
      S_WIN1: begin
        if (start_edge_c || (tick_q && cnt_q == WIN_LAST)) state_d = S_LOAD2;
      end
      S_WIN2: begin
        if (start_edge_c || (tick_q && cnt_q == WIN_LAST)) state_d = S_TITLE;
      end
      default: state_d = S_TITLE;
    endcase

    entering_c = (state_d != state_q);
    to_load_c  = (state_d == S_LOAD1) || (state_d == S_LOAD2);

    // State entry overrides any same-cycle tick update.
    if (entering_c) begin
      cnt_d = '0;
      if (to_load_c) begin
        idx_d  = '0;
        blk_d  = '0;
        rect_d = '0;
      end
      if (state_d == S_TITLE) begin
        blk_d    = '0;
        rect_d   = '0;
        pstart_d = 1'b1;
      end
    end
    if (state_d != S_TITLE) pstart_d = 1'b0;

    title_d        = (state_d == S_TITLE);
    level_one_d    = (state_d == S_LOAD1) || (state_d == S_PLAY1) || (state_d == S_WIN1);
    level_two_d    = (state_d == S_LOAD2) || (state_d == S_PLAY2) || (state_d == S_WIN2);
    level_active_d = (state_d == S_PLAY1) || (state_d == S_PLAY2);
    level_load_d   = entering_c && to_load_c;
  end

  // State, counters, synchronizer and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= S_TITLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      blk_q          <= '0;
      rect_q         <= '0;
      title_q        <= 1'b1;
      pstart_q       <= 1'b1;
      level_one_q    <= 1'b0;
      level_two_q    <= 1'b0;
      level_active_q <= 1'b0;
      level_load_q   <= 1'b0;
      fsync1_q       <= 1'b0;
      fsync2_q       <= 1'b0;
      fsync3_q       <= 1'b0;
      tick_q         <= 1'b0;
      start_prev_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      blk_q          <= blk_d;
      rect_q         <= rect_d;
      title_q        <= title_d;
      pstart_q       <= pstart_d;
      level_one_q    <= level_one_d;
      level_two_q    <= level_two_d;
      level_active_q <= level_active_d;
      level_load_q   <= level_load_d;
      fsync1_q       <= frame_clk;
      fsync2_q       <= fsync1_q;
      fsync3_q       <= fsync2_q;
      tick_q         <= tick_d;
      start_prev_q   <= start_key;
    end
  end

  assign title        = title_q;
  assign pstart       = pstart_q;
  assign level_one    = level_one_q;
  assign level_two    = level_two_q;
  assign level_active = level_active_q;
  assign level_load   = level_load_q;
  assign block_ready  = blk_q;
  assign rect_ready   = rect_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed bench for game_flow_ctrl with a per-cycle
// behavioural model (phase/level/reveal-count view) plus literal checkpoints.
module tb_game_flow_ctrl;

  localparam int unsigned BF = 3;
  localparam int unsigned RF = 2;
  localparam int unsigned WF = 4;

  logic       clk;
  logic       reset;
  logic       frame_clk;
  logic       start_key;
  logic       level_done;
  logic       ball_dead;
  logic       title, pstart, level_one, level_two, level_active, level_load;
  logic [0:9] block_ready;
  logic [0:2] rect_ready;

  int total = 0;
  int bad   = 0;

  game_flow_ctrl #(
    .BLINK_FRAMES(BF), .REVEAL_FRAMES(RF), .WIN_HOLD_FRAMES(WF)
  ) dut (
    .Clk(clk), .Reset(reset), .frame_clk(frame_clk), .start_key(start_key),
    .level_done(level_done), .ball_dead(ball_dead),
    .title(title), .pstart(pstart), .level_one(level_one), .level_two(level_two),
    .level_active(level_active), .level_load(level_load),
    .block_ready(block_ready), .rect_ready(rect_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0=title 1=load 2=play 3=win; level 1/2; blocks revealed as a count.
  int   m_phase, m_lvl, m_cnt, m_rev, m_rect;
  bit   m_pst, m_load, m_kprev, armed;
  bit   fs1, fs2, fs3, fs4;
  bit   tk, se;

  function automatic logic [18:0] model_out();
    logic [0:9] b;
    logic [0:2] r;
    for (int i = 0; i < 10; i++) b[i] = (i < m_rev);
    r = (m_rect == 0) ? 3'b000 : ((m_rect == 1) ? 3'b100 : 3'b111);
    return {(m_phase == 0), ((m_phase == 0) && m_pst),
            ((m_phase != 0) && (m_lvl == 1)), ((m_phase != 0) && (m_lvl == 2)),
            (m_phase == 2), m_load, b, r};
  endfunction

  function automatic void enter_load(int lvl);
    m_phase = 1; m_lvl = lvl; m_cnt = 0; m_rev = 0; m_rect = 0; m_load = 1'b1;
  endfunction

  always @(posedge clk) begin
    armed = 1'b1;
    if (reset) begin
      m_phase = 0; m_lvl = 1; m_cnt = 0; m_rev = 0; m_rect = 0;
      m_pst = 1'b1; m_load = 1'b0; m_kprev = 1'b0;
      fs1 = 0; fs2 = 0; fs3 = 0; fs4 = 0;
    end else begin
      // A frame_clk rise sampled three edges ago is acted on now.
      tk = fs3 & ~fs4;
      se = start_key & ~m_kprev;
      m_load = 1'b0;
      case (m_phase)
        0: begin
          if (se) enter_load(1);
          else if (tk) begin
            if (m_cnt == BF - 1) begin m_pst = ~m_pst; m_cnt = 0; end
            else m_cnt++;
          end
        end
        1: begin
          if (tk) begin
            if (m_cnt == RF - 1) begin
              m_cnt = 0;
              if (m_rev < ((m_lvl == 1) ? 5 : 10)) m_rev++;
              else begin m_rect = (m_lvl == 1) ? 1 : 3; m_phase = 2; end
            end else m_cnt++;
          end
        end
        2: begin
          if (level_done) begin m_phase = 3; m_cnt = 0; end
          else if (ball_dead) enter_load(m_lvl);
        end
        default: begin
          if (se || (tk && m_cnt == WF - 1)) begin
            if (m_lvl == 1) enter_load(2);
            else begin
              m_phase = 0; m_cnt = 0; m_rev = 0; m_rect = 0; m_pst = 1'b1;
            end
          end else if (tk) m_cnt++;
        end
      endcase
      m_kprev = start_key;
      fs4 = fs3; fs3 = fs2; fs2 = fs1; fs1 = frame_clk;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [18:0] d;
    logic [18:0] e;
    if (armed) begin
      d = {title, pstart, level_one, level_two, level_active, level_load, block_ready, rect_ready};
      e = model_out();
      total++;
      if (d !== e) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t got=%b want=%b", $time, d, e);
      end
    end
  end

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // One frame_clk pulse; returns in the cycle where the internal tick is present.
  task automatic frame_pulse();
    @(negedge clk) frame_clk = 1'b1;
    @(negedge clk);
    @(negedge clk) frame_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) frame_pulse();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_blink [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    reset = 1'b1; frame_clk = 1'b0; start_key = 1'b0; level_done = 1'b0; ball_dead = 1'b0;
    repeat (2) @(negedge clk);
    pin("reset_vals", 32'({title, pstart, level_one, level_two, level_active, level_load,
                          block_ready, rect_ready}), 32'h60000);
    reset = 1'b0;

    // Title blink.
    for (int k = 0; k < 7; k++) begin
      frame_pulse();
      pin("blink_pstart", 32'(pstart), 32'(exp_blink[k]));
      pin("blink_title", 32'(title), 32'd1);
    end

    // Start edge -> LOAD1; key stays held through the reveal.
    @(negedge clk) start_key = 1'b1;
    @(negedge clk) pin("start_flags", 32'({title, pstart, level_one, level_load}), 32'b0011);
    @(negedge clk) pin("load_pulse_len", 32'(level_load), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      frame_pulse();
      if (k == 11)
        pin("pre_rect", 32'({block_ready, rect_ready, level_active}),
            32'({10'b1111100000, 3'b000, 1'b0}));
    end
    @(negedge clk);
    pin("play1", 32'({block_ready, rect_ready, level_active}), 32'({10'b1111100000, 3'b100, 1'b1}));
    start_key = 1'b0;

    // Start edge ignored during play.
    @(negedge clk) start_key = 1'b1;
    @(negedge clk) pin("start_in_play", 32'(level_active), 32'd1);
    start_key = 1'b0;

    // Ball lost -> re-reveal.
    @(negedge clk) ball_dead = 1'b1;
    @(negedge clk) ball_dead = 1'b0;
    pin("dead_reload", 32'({level_load, level_active, level_one, block_ready, rect_ready}),
        32'({1'b1, 1'b0, 1'b1, 10'b0, 3'b000}));
    pulses(12);
    @(negedge clk) pin("play1_again", 32'(level_active), 32'd1);

    // level_done beats ball_dead.
    @(negedge clk) begin level_done = 1'b1; ball_dead = 1'b1; end
    @(negedge clk) begin level_done = 1'b0; ball_dead = 1'b0; end
    pin("win1", 32'({level_active, level_one, block_ready, rect_ready}),
        32'({1'b0, 1'b1, 10'b1111100000, 3'b100}));
    pulses(4);
    @(negedge clk);
    pin("load2", 32'({level_one, level_two, level_load, block_ready}), 32'({3'b011, 10'b0}));
    pulses(22);
    @(negedge clk);
    pin("play2", 32'({block_ready, rect_ready, level_active}), 32'({10'b1111111111, 3'b111, 1'b1}));

    // WIN2, one tick, then start edge -> TITLE.
    @(negedge clk) level_done = 1'b1;
    @(negedge clk) level_done = 1'b0;
    frame_pulse();
    @(negedge clk) start_key = 1'b1;
    @(negedge clk);
    pin("win2_to_title", 32'({title, pstart, level_two, block_ready, rect_ready}),
        32'({3'b110, 10'b0, 3'b000}));
    start_key = 1'b0;

    // Back to LOAD2, reveal three blocks, then reset.
    @(negedge clk) start_key = 1'b1;
    @(negedge clk) start_key = 1'b0;
    pulses(12);
    @(negedge clk) level_done = 1'b1;
    @(negedge clk) level_done = 1'b0;
    @(negedge clk) start_key = 1'b1;
    @(negedge clk) start_key = 1'b0;
    pulses(6);
    @(negedge clk);
    pin("load2_partial", 32'({level_two, block_ready}), 32'({1'b1, 10'b1110000000}));
    reset = 1'b1;
    @(negedge clk);
    pin("mid_reset", 32'({title, pstart, level_one, level_two, level_active, level_load,
                         block_ready, rect_ready}), 32'h60000);
    reset = 1'b0;
    frame_pulse();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Game-flow sequencer for the VGA display path. It steps through title screen, level one, level two and back. It drives the mode flags (title, pstart, level_one, level_two) and the per-object enables (block_ready, rect_ready) that color_mapper consumes, staggering block appearance frame by frame. It also issues a load pulse so the ball/block motion modules reposition at each level (re)start.

## Interface
Parameters:
- BLINK_FRAMES, 30: frame ticks per half-period of the "press start" blink (1..255).
- REVEAL_FRAMES, 4: frame ticks between successive object reveals during load (1..255).
- WIN_HOLD_FRAMES, 120: frame ticks held in a win state before advancing (1..255).

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  VGA vertical sync; rising edge = one frame.
- start_key  in  1  decoded Enter key, level; rising edge used.
- level_done  in  1  game logic: all current-level blocks painted.
- ball_dead  in  1  game logic: a ball was lost.
- title  out  1  title screen active.
- pstart  out  1  "press start" text visible (blinks).
- level_one  out  1  level-one banner/mode.
- level_two  out  1  level-two banner/mode.
- level_active  out  1  play permitted; ball motion enable.
- level_load  out  1  one-cycle pulse on entry to a load state.
- block_ready  out  [0:9]  per-block draw/collide enable.
- rect_ready  out  [0:2]  per-rectangle draw/collide enable.

## Operation
- Frame tick: frame_clk passes a 2-flop synchronizer, then a rising-edge register. `tick` is high for one Clk.
- start_key is edge-detected against its registered previous value. level_done and ball_dead are level-sampled only in PLAY states.
- States: TITLE, LOAD1, PLAY1, WIN1, LOAD2, PLAY2, WIN2. Reset -> TITLE.
- Transitions:
  - TITLE: start edge -> LOAD1.
  - LOADx: reveal complete -> PLAYx.
  - PLAYx:
    - level_done -> WINx.
    - Otherwise ball_dead -> LOADx (re-reveal).
    - level_done wins if both are high.
  - WIN1: hold expiry or start edge -> LOAD2.
  - WIN2: hold expiry or start edge -> TITLE.
- An 8-bit frame counter clears on every state entry and increments on each tick.
- Reveal in LOADx:
  - On entry, reveal_idx=0 and all block_ready/rect_ready are cleared.
  - Each time counter==REVEAL_FRAMES-1 on a tick, block_ready[reveal_idx] is set, reveal_idx increments and the counter clears.
  - Level one reveals blocks 0..4. Level two reveals blocks 0..9.
  - The reveal step after the last block sets rect_ready: [0] for level one, [0:2] for level two. The state moves to PLAYx on the same cycle.
  - Unused block_ready and rect_ready bits stay 0.
- WINx exits on the tick where counter==WIN_HOLD_FRAMES-1. block_ready and rect_ready hold their values.
- Flag outputs by state:
  - title=1 only in TITLE.
  - level_one=1 in LOAD1, PLAY1, WIN1.
  - level_two=1 in LOAD2, PLAY2, WIN2.
  - level_active=1 only in PLAY1 and PLAY2.
- pstart:
  - Set to 1 on TITLE entry.
  - In TITLE, toggles on each tick where counter==BLINK_FRAMES-1; the counter then clears.
  - Forced to 0 outside TITLE.
- Entering TITLE from WIN2 clears all ready bits.

## Timing
- All outputs are registered.
- Reset values: title=1, pstart=1, level_one=0, level_two=0, level_active=0, level_load=0, block_ready=0, rect_ready=0.
- Reset asserted mid-operation returns to TITLE on the next edge with the reset values; no partial reveal survives.
- frame_clk rise -> tick: 3 Clk.
- tick -> updated block_ready, rect_ready, pstart or state: 1 Clk.
- start edge / level_done / ball_dead -> new state and flags: 1 Clk after the sampling edge.
- level_load is high exactly the first cycle in LOADx, including ball_dead re-entries.
- LOAD1 duration = 6·REVEAL_FRAMES ticks. LOAD2 duration = 11·REVEAL_FRAMES ticks.
- start_key held high produces only one edge; a start edge during LOADx or PLAYx is ignored.
- A tick and an event in the same cycle: the event transition takes priority; the counter clears on entry.

## Test plan
Parameters for all scenarios: BLINK_FRAMES=3, REVEAL_FRAMES=2, WIN_HOLD_FRAMES=4.
- Reset, then 7 frame ticks with no key -> title=1 throughout; pstart=1,1,1,0,0,0,1 after ticks 1..7; all other outputs 0.
- Start edge in TITLE -> next cycle: level_one=1, title=0, pstart=0, level_load=1 for one cycle. block_ready bits 0..4 set after ticks 2,4,6,8,10. At tick 12, rect_ready=100 and level_active=1.
- In PLAY1, pulse ball_dead -> LOAD1 re-entered: level_load pulse, block_ready=0, rect_ready=0, level_active=0; the full reveal repeats.
- In PLAY1, assert level_done and ball_dead together -> WIN1; block_ready stays 0..4 set. After 4 ticks -> LOAD2 with level_two=1; at tick 22, blocks 0..9 and rect_ready=111 are set.
- In WIN2, start edge after 1 tick -> TITLE immediately: title=1, pstart=1, all ready bits 0.
- Assert Reset mid-LOAD2 with 3 blocks revealed -> next cycle all outputs at reset values, state TITLE.
